// File: rtl/usb_cmd_arbiter_if.sv
// Bundle of the two requester channels and the interpreter-facing outputs of usb_cmd_arbiter.
// The arbiter takes the slave view; requesters and the bench take the master view.
interface usb_cmd_arbiter_if;
  logic        usb_valid;
  logic [16:1] usb_word;
  logic        usb_ready;
  logic        seq_valid;
  logic [16:1] seq_word;
  logic        seq_last;
  logic        seq_ready;
  logic        out_to_interpreter_rd_en;
  logic [16:1] out_to_interpreter_word;
  logic        grant_seq;
  logic        busy;
  logic        lock_abort;

  modport slave (
    input  usb_valid,
    input  usb_word,
    output usb_ready,
    input  seq_valid,
    input  seq_word,
    input  seq_last,
    output seq_ready,
    output out_to_interpreter_rd_en,
    output out_to_interpreter_word,
    output grant_seq,
    output busy,
    output lock_abort
  );

  modport master (
    output usb_valid,
    output usb_word,
    input  usb_ready,
    output seq_valid,
    output seq_word,
    output seq_last,
    input  seq_ready,
    input  out_to_interpreter_rd_en,
    input  out_to_interpreter_word,
    input  grant_seq,
    input  busy,
    input  lock_abort
  );
endinterface

// File: rtl/usb_cmd_arbiter.sv
// Round-robin arbiter feeding usb_command_interpreter from the host stream and the scan sequencer.
// Optional atomic sequencer bursts with a lock timeout are compiled in by CMD_ARB_BURST_LOCK_EN.
module usb_cmd_arbiter #(
  parameter int GAP_CYCLES   = 3,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic             clk,
  input logic             reset,
  usb_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gapCnt_q, gapCnt_d;
  logic [16:1] word_q, word_d;
  logic        grantSeq_q, grantSeq_d;
  logic        favourSeq_q, favourSeq_d;

  logic usbReady, seqReady;
  logic usbXfer, seqXfer;
  logic locked;

`ifdef CMD_ARB_BURST_LOCK_EN
  localparam int LockCntW = $clog2(LOCK_TIMEOUT + 1);

  logic                lock_q, lock_d;
  logic [LockCntW-1:0] lockCnt_q, lockCnt_d;
  logic                abort_q, abort_d;

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  // Grant decision; a held lock shuts the host out, otherwise ties go to the favoured side.
  always_comb begin
    usbReady = 1'b0;
    seqReady = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (locked) begin
        seqReady = bus.seq_valid;
      end else if (bus.seq_valid && (!bus.usb_valid || favourSeq_q)) begin
        seqReady = 1'b1;
      end else begin
        usbReady = bus.usb_valid;
      end
    end
  end

  assign usbXfer = bus.usb_valid & usbReady;
  assign seqXfer = bus.seq_valid & seqReady;

  // Issue sequencing: accept in IDLE, strobe for one cycle, then hold off for the gap.
  always_comb begin
    state_d     = state_q;
    gapCnt_d    = gapCnt_q;
    word_d      = word_q;
    grantSeq_d  = grantSeq_q;
    favourSeq_d = favourSeq_q;
    case (state_q)
      IDLE: begin
        if (seqXfer) begin
          word_d      = bus.seq_word;
          grantSeq_d  = 1'b1;
          favourSeq_d = 1'b0;
          state_d     = ISSUE;
        end else if (usbXfer) begin
          word_d      = bus.usb_word;
          grantSeq_d  = 1'b0;
          favourSeq_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (GAP_CYCLES > 0) begin
          gapCnt_d = 4'(GAP_CYCLES - 1);
          state_d  = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gapCnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gapCnt_q    <= 4'd0;
      word_q      <= 16'h0000;
      grantSeq_q  <= 1'b0;
      favourSeq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gapCnt_q    <= gapCnt_d;
      word_q      <= word_d;
      grantSeq_q  <= grantSeq_d;
      favourSeq_q <= favourSeq_d;
    end
  end

`ifdef CMD_ARB_BURST_LOCK_EN
  // A sequencer transfer wins over a coincident timeout, so a late word keeps its burst alive.
  always_comb begin
    lock_d    = lock_q;
    lockCnt_d = lockCnt_q;
    abort_d   = 1'b0;
    if (seqXfer) begin
      lock_d    = ~bus.seq_last;
      lockCnt_d = '0;
    end else if (lock_q && lockCnt_q == LockCntW'(LOCK_TIMEOUT)) begin
      lock_d    = 1'b0;
      lockCnt_d = '0;
      abort_d   = 1'b1;
    end else if (lock_q && state_q == IDLE && !bus.seq_valid) begin
      lockCnt_d = lockCnt_q + LockCntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lockCnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lockCnt_q <= lockCnt_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.lock_abort = abort_q;
`else
  assign bus.lock_abort = 1'b0;
`endif

  assign bus.usb_ready                = usbReady;
  assign bus.seq_ready                = seqReady;
  assign bus.out_to_interpreter_rd_en = (state_q == ISSUE);
  assign bus.out_to_interpreter_word  = word_q;
  assign bus.grant_seq                = grantSeq_q;
  assign bus.busy                     = (state_q != IDLE) | locked;

endmodule

// File: tb/tb_usb_cmd_arbiter.sv
// Directed scoreboard bench for usb_cmd_arbiter: one GAP_CYCLES=3/LOCK_TIMEOUT=16 instance and one GAP_CYCLES=0 instance.
// Lock-specific expectations follow CMD_ARB_BURST_LOCK_EN.
module tb_usb_cmd_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_cmd_arbiter_if aIf ();
  usb_cmd_arbiter_if bIf ();

  usb_cmd_arbiter #(.GAP_CYCLES(3), .LOCK_TIMEOUT(16)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (aIf)
  );

  usb_cmd_arbiter #(.GAP_CYCLES(0), .LOCK_TIMEOUT(16)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (bIf)
  );

  int checks   = 0;
  int failures = 0;

  // Driver queues: usb words, and sequencer entries with bit 16 = last.
  logic [15:0] usbQ[$];
  logic [16:0] seqQ[$];
  // Scoreboard entries: bit 16 = expected grant_seq, [15:0] = expected word.
  logic [16:0] expQ[$];

  logic        sUsbReady, sSeqReady, sRdEn, sBusy, sAbort, sGrant;
  logic [15:0] sWord;
  int          sCyc;
  int          lastSeqTake   = -1;
  int          abortCount    = 0;
  int          lastAbortCyc  = -1;
  int          lastStrobeCyc = -1;
  int          prevStrobe    = -1;
  bit          chkSpacing    = 0;
  logic [16:0] monExp;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic loadDrivers();
    logic [16:0] s;
    if (!aIf.usb_valid && usbQ.size() > 0) begin
      aIf.usb_word  = usbQ.pop_front();
      aIf.usb_valid = 1'b1;
    end
    if (!aIf.seq_valid && seqQ.size() > 0) begin
      s             = seqQ.pop_front();
      aIf.seq_word  = s[15:0];
      aIf.seq_last  = s[16];
      aIf.seq_valid = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit isSeq, input logic [15:0] w, input bit last);
    if (isSeq) seqQ.push_back({last, w});
    else       usbQ.push_back(w);
    loadDrivers();
  endtask

  task automatic expectIssue(input bit isSeq, input logic [15:0] w);
    expQ.push_back({isSeq, w});
  endtask

  // One cycle: sample at the falling edge, then retire accepted words after the rising edge.
  task automatic step();
    bit uT, sT;
    @(negedge clk);
    sUsbReady = aIf.usb_ready;
    sSeqReady = aIf.seq_ready;
    sRdEn     = aIf.out_to_interpreter_rd_en;
    sBusy     = aIf.busy;
    sAbort    = aIf.lock_abort;
    sGrant    = aIf.grant_seq;
    sWord     = aIf.out_to_interpreter_word;
    sCyc      = cyc;
    uT = aIf.usb_valid && aIf.usb_ready;
    sT = aIf.seq_valid && aIf.seq_ready;
    if (sT) lastSeqTake = cyc;
    @(posedge clk);
    #1;
    if (uT) aIf.usb_valid = 1'b0;
    if (sT) aIf.seq_valid = 1'b0;
    loadDrivers();
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || aIf.usb_valid || aIf.seq_valid) && n < 200) begin
      step();
      n++;
    end
    repeat (8) step();
    checkOutput({tag, "_drained"}, expQ.size(), 0);
  endtask

  // Scoreboard side: every strobe pops the next expected issue.
  always @(negedge clk) begin
    if (aIf.lock_abort === 1'b1) begin
      abortCount++;
      lastAbortCyc = cyc;
    end
    if (aIf.out_to_interpreter_rd_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", {16'h0, aIf.out_to_interpreter_word}, 32'hFFFF_FFFF);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("strobe_word", aIf.out_to_interpreter_word, monExp[15:0]);
        checkOutput("strobe_owner", aIf.grant_seq, monExp[16]);
      end
      if (chkSpacing && prevStrobe >= 0) checkOutput("strobe_spacing", cyc - prevStrobe, 5);
      prevStrobe    = cyc;
      lastStrobeCyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [0:6] rdPat, busyPat, readyPat;
    int         t, n;

    reset = 1'b1;
    aIf.usb_valid = 0; aIf.usb_word = 0; aIf.seq_valid = 0; aIf.seq_word = 0; aIf.seq_last = 0;
    bIf.usb_valid = 0; bIf.usb_word = 0; bIf.seq_valid = 0; bIf.seq_word = 0; bIf.seq_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rd_en", aIf.out_to_interpreter_rd_en, 0);
    checkOutput("rst_word", aIf.out_to_interpreter_word, 16'h0000);
    checkOutput("rst_usb_ready", aIf.usb_ready, 0);
    checkOutput("rst_seq_ready", aIf.seq_ready, 0);
    checkOutput("rst_grant_seq", aIf.grant_seq, 0);
    checkOutput("rst_busy", aIf.busy, 0);
    checkOutput("rst_lock_abort", aIf.lock_abort, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] reset released at cycle %0d", cyc);

    // GAP_CYCLES=0: back-to-back host words strobe every other cycle.
    bIf.usb_word = 16'h0001; bIf.usb_valid = 1'b1;
    @(negedge clk);
    checkOutput("g0_ready_t0", bIf.usb_ready, 1);
    checkOutput("g0_rd_t0", bIf.out_to_interpreter_rd_en, 0);
    @(posedge clk); #1 bIf.usb_word = 16'h0002;
    @(negedge clk);
    checkOutput("g0_rd_t1", bIf.out_to_interpreter_rd_en, 1);
    checkOutput("g0_word_t1", bIf.out_to_interpreter_word, 16'h0001);
    checkOutput("g0_ready_t1", bIf.usb_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("g0_ready_t2", bIf.usb_ready, 1);
    checkOutput("g0_rd_t2", bIf.out_to_interpreter_rd_en, 0);
    @(posedge clk); #1 bIf.usb_valid = 1'b0;
    @(negedge clk);
    checkOutput("g0_rd_t3", bIf.out_to_interpreter_rd_en, 1);
    checkOutput("g0_word_t3", bIf.out_to_interpreter_word, 16'h0002);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("g0_rd_t4", bIf.out_to_interpreter_rd_en, 0);
    @(posedge clk); #1;

    // Single host word with GAP_CYCLES=3, then a second one to observe ready returning.
    $display("[TB] single host word");
    applyStimulus(0, 16'h55AA, 0); expectIssue(0, 16'h55AA);
    applyStimulus(0, 16'h55AB, 0); expectIssue(0, 16'h55AB);
    rdPat    = 7'b0100001;
    busyPat  = 7'b0111101;
    readyPat = 7'b1000010;
    for (int k = 0; k < 7; k++) begin
      step();
      checkOutput($sformatf("single_rd_en_%0d", k), sRdEn, rdPat[k]);
      checkOutput($sformatf("single_busy_%0d", k), sBusy, busyPat[k]);
      checkOutput($sformatf("single_usb_ready_%0d", k), sUsbReady, readyPat[k]);
    end
    waitDrain("single");

    // Sequencer burst with the host waiting throughout; sequencer is favoured after the last host grant.
    $display("[TB] sequencer burst");
    applyStimulus(1, 16'hA001, 0);
    applyStimulus(1, 16'hA002, 0);
    applyStimulus(1, 16'hA003, 1);
    applyStimulus(0, 16'hB001, 0);
`ifdef CMD_ARB_BURST_LOCK_EN
    expectIssue(1, 16'hA001); expectIssue(1, 16'hA002); expectIssue(1, 16'hA003); expectIssue(0, 16'hB001);
`else
    expectIssue(1, 16'hA001); expectIssue(0, 16'hB001); expectIssue(1, 16'hA002); expectIssue(1, 16'hA003);
`endif
    waitDrain("burst");
    checkOutput("burst_idle_busy", sBusy, 0);

    // Stalled burst: lock must time out and let a waiting host word through.
    $display("[TB] stalled burst");
    abortCount  = 0;
    lastSeqTake = -1;
    applyStimulus(1, 16'hA001, 0); expectIssue(1, 16'hA001);
    n = 0;
    while (lastSeqTake < 0 && n < 20) begin
      step();
      n++;
    end
    checkOutput("stall_seq_taken", (lastSeqTake >= 0), 1);
    t = lastSeqTake;
    applyStimulus(0, 16'hC001, 0); expectIssue(0, 16'hC001);
    while (cyc < t + 30) begin
      step();
      if (sCyc == t + 12) checkOutput("stall_busy_mid",
`ifdef CMD_ARB_BURST_LOCK_EN
        sBusy, 1);
`else
        sBusy, 0);
`endif
    end
`ifdef CMD_ARB_BURST_LOCK_EN
    checkOutput("stall_abort_count", abortCount, 1);
    checkOutput("stall_abort_cycle", lastAbortCyc - t, 22);
    checkOutput("stall_usb_strobe_cycle", lastStrobeCyc - t, 23);
`else
    checkOutput("stall_abort_count", abortCount, 0);
    checkOutput("stall_usb_strobe_cycle", lastStrobeCyc - t, 6);
`endif
    waitDrain("stall");

    // Both requesters saturated from reset: strict alternation, USB first, 5-cycle spacing.
    $display("[TB] saturated round-robin");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chkSpacing = 1;
    prevStrobe = -1;
    applyStimulus(0, 16'hFFC0, 0); applyStimulus(0, 16'hFFC0, 0);
    applyStimulus(1, 16'hFFD0, 1); applyStimulus(1, 16'hFFD0, 1);
    expectIssue(0, 16'hFFC0); expectIssue(1, 16'hFFD0);
    expectIssue(0, 16'hFFC0); expectIssue(1, 16'hFFD0);
    waitDrain("rr");
    chkSpacing = 0;

    // Reset during the gap: state drops, no strobe, and the next tie goes to USB.
    $display("[TB] reset in gap");
    applyStimulus(0, 16'h1234, 0); expectIssue(0, 16'h1234);
    n = 0;
    do begin
      step();
      n++;
    end while (sRdEn !== 1'b1 && n < 10);
    checkOutput("rg_strobe_seen", sRdEn, 1);
    reset = 1'b1;
    applyStimulus(0, 16'hDDDD, 0);
    applyStimulus(1, 16'hEEEE, 1);
    expectIssue(0, 16'hDDDD); expectIssue(1, 16'hEEEE);
    step();
    checkOutput("rg_usb_ready_in_reset", sUsbReady, 0);
    checkOutput("rg_seq_ready_in_reset", sSeqReady, 0);
    step();
    checkOutput("rg_rd_en", sRdEn, 0);
    checkOutput("rg_word", sWord, 16'h0000);
    checkOutput("rg_grant_seq", sGrant, 0);
    checkOutput("rg_busy", sBusy, 0);
    checkOutput("rg_abort", sAbort, 0);
    reset = 1'b0;
    waitDrain("rg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_cmd_arbiter.md
# usb_cmd_arbiter

Shares the single 16-bit control-word input of `usb_command_interpreter` between two requesters: the USB command stream from the host and the on-board scan sequencer that replays configuration words (DAC scan, HV setup). It sits directly upstream of the interpreter. It round-robins requests, issues each accepted word as a one-cycle read-enable strobe, and enforces a minimum idle gap so the interpreter finishes decoding before the next word arrives. Multi-word sequencer bursts can optionally be made atomic.

## Interface
- `GAP_CYCLES`, default 3: idle cycles forced after each issued strobe; legal range 0..15.
- `LOCK_TIMEOUT`, default 1024: cycles a held burst lock survives with no sequencer word before it is aborted; must be at least 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  **synchronous, active-high** reset.
- `usb_valid`  in  1  host word available.
- `usb_word`  in  [16:1]  host control word.
- `usb_ready`  out  1  arbiter accepts the host word this cycle.
- `seq_valid`  in  1  sequencer word available.
- `seq_word`  in  [16:1]  sequencer control word.
- `seq_last`  in  1  marks the final word of a sequencer burst.
- `seq_ready`  out  1  arbiter accepts the sequencer word this cycle.
- `out_to_interpreter_rd_en`  out  1  one-cycle strobe to the interpreter's `in_from_usb_Ctr_rd_en`.
- `out_to_interpreter_word`  out  [16:1]  word presented to `in_from_usb_ControlWord`; holds its value between strobes.
- `grant_seq`  out  1  owner of the most recent issue: 1 = sequencer, 0 = USB.
- `busy`  out  1  high in ISSUE and GAP, and whenever a burst lock is held.
- `lock_abort`  out  1  one-cycle pulse when the burst lock times out.

## Operation
- FSM states: IDLE, ISSUE, GAP.
- A transfer occurs when `valid && ready`. The ready signals are combinational, high only in IDLE and only for the granted requester.
- Grant rules in IDLE:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins (round-robin).
  - After reset, USB wins the first tie.
- IDLE → ISSUE on any transfer. The word is registered into `out_to_interpreter_word` and `grant_seq` is updated.
- ISSUE lasts 1 cycle with `rd_en`=1.
  - ISSUE → GAP when `GAP_CYCLES`>0.
  - ISSUE → IDLE when `GAP_CYCLES`=0.
- GAP counts `GAP_CYCLES` cycles with `rd_en`=0, then returns to IDLE. No ready is asserted during ISSUE or GAP.
- Burst lock (when compiled in):
  - Setting: a sequencer transfer with `seq_last`=0 sets the lock.
  - While locked: `usb_ready`=0 and only the sequencer is granted.
  - Clearing: a sequencer transfer with `seq_last`=1 clears the lock. That word is still issued normally.
  - Timeout: the lock counter increments on each IDLE cycle while locked with `seq_valid`=0 and resets on any sequencer transfer. At `LOCK_TIMEOUT`, the lock clears and `lock_abort` pulses once. USB may be granted in the next IDLE cycle.
- Reset values: `rd_en`=0, `out_to_interpreter_word`=16'h0000, `usb_ready`=0, `seq_ready`=0, `grant_seq`=0, `busy`=0, `lock_abort`=0. The FSM enters IDLE, the lock is cleared, and the round-robin pointer favours USB.
- Reset mid-operation: a pending strobe or gap is dropped and no strobe is emitted after reset. A word accepted in the cycle that reset is asserted is discarded.

## Timing
- Accept at cycle T → `rd_en` high at T+1, with the word valid at T+1.
- Next earliest accept: T+2+`GAP_CYCLES`.
- Strobe spacing: at least `GAP_CYCLES`+2 cycles; exactly that under back-to-back load.
- A requester must hold `valid` and its word stable until `ready`. Dropping `valid` before `ready` withdraws the request with no side effects.
- `ready` depends only on state, lock, the round-robin pointer and the two `valid` inputs. It never depends on `seq_word` or `usb_word`.
- `lock_abort` is asserted in the cycle after the counter reaches `LOCK_TIMEOUT`, coincident with the lock clearing.

## Configuration
- Macro: `CMD_ARB_BURST_LOCK_EN`.
- Defined: the burst lock, the timeout counter and `lock_abort` are implemented as described in Operation.
- Undefined: `seq_last` is ignored, every word is arbitrated independently by round-robin, `lock_abort` is tied to 0, and `busy` reflects ISSUE/GAP only.

## Test plan
- Single USB word 16'h55AA accepted at T → `rd_en`=1 only at T+1 with word 16'h55AA; `busy` high T+1..T+4 with GAP=3; `usb_ready` returns at T+5.
- USB and sequencer both valid continuously, words 16'hFFC0 and 16'hFFD0 → issued order USB, SEQ, USB, SEQ with strobes 5 cycles apart.
- Lock enabled, sequencer burst 16'hA001, 16'hA002, 16'hA003 (last on the third) with USB valid throughout → all three sequencer words issue before any USB word; USB is issued right after.
- Lock enabled, sequencer sends 16'hA001 (last=0) then stalls, `LOCK_TIMEOUT`=16 → `lock_abort` pulses once after 16 IDLE cycles; a waiting USB word then issues.
- Reset asserted during GAP after issuing 16'h1234 → the next cycle shows all outputs at reset values, no further strobe, and the first tie after release goes to USB.
- `GAP_CYCLES`=0, USB back-to-back 16'h0001, 16'h0002 → strobes on alternating cycles (spacing 2).
